// File: rtl/wnn_test_pkg.sv
// Shared definitions for the WNN stream tester.
//   state_t  : tester FSM states
//   label_t  : label/result type for the default 4-bit label geometry
//   ceil_div : integer ceiling division used to size the chunk count
package wnn_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DRAIN,
    DONE
  } state_t;

  localparam int DEFAULT_LABEL_W = 4;
  typedef logic [DEFAULT_LABEL_W-1:0] label_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/label_fifo.sv
// Synchronous show-ahead FIFO holding the expected labels of samples in flight.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        empty the FIFO (pointer reset), takes priority over push/pop
//   push, din    write din when push (honoured when full if pop is also set)
//   pop          drop the head entry (ignored when empty)
//   head         current head entry, valid while !empty
//   full, empty  occupancy flags
module label_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/wnn_stream_tester.sv
// On-chip self-test harness for the WNN inference interface. Reads labelled
// samples from a sample ROM, streams each sample to the DUT in BUS_W chunks
// (honouring stall), queues expected labels and scores DUT results.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin a run (from IDLE/DONE) / return to IDLE
//   smp_rd_en, smp_addr   ROM read strobe and sample index
//   smp_data, smp_label   ROM sample and label, valid 1 cycle after smp_rd_en
//   dut_inp_vld, dut_inp  chunk stream to the DUT
//   dut_stall             DUT did not accept the chunk this cycle
//   dut_outp_vld/dut_outp DUT result pulse and predicted class
//   busy, done            run status
//   samples_seen          results received this run
//   correct_cnt           results matching the queued label
//   err_underflow         sticky: result arrived with no label queued
module wnn_stream_tester
  import wnn_test_pkg::*;
#(
  parameter int  INPUT_BITS  = 784,
  parameter int  BUS_W       = 64,
  parameter int  LABEL_W     = 4,
  parameter int  NUM_SAMPLES = 10000,
  parameter int  FIFO_DEPTH  = 8,
  localparam int NCHUNK      = ceil_div(INPUT_BITS, BUS_W),
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1),
  localparam int ADDR_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  smp_rd_en,
  output logic [ADDR_W-1:0]     smp_addr,
  input  logic [INPUT_BITS-1:0] smp_data,
  input  logic [LABEL_W-1:0]    smp_label,
  output logic                  dut_inp_vld,
  output logic [BUS_W-1:0]      dut_inp,
  input  logic                  dut_stall,
  input  logic                  dut_outp_vld,
  input  logic [LABEL_W-1:0]    dut_outp,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      samples_seen,
  output logic [CNT_W-1:0]      correct_cnt,
  output logic                  err_underflow
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W = NCHUNK * BUS_W;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCHUNK - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NUM_SAMPLES);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [PAD_W-1:0]   padded;
  logic [LABEL_W-1:0] label_q;
  logic [LABEL_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               idle_or_done;
  logic               accept;
  logic               last_chunk;
  logic               result_ok;

  // Status and handshake outputs are pure decodes of the state register.
  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign busy         = !idle_or_done;
  assign done         = (state == DONE);
  assign smp_rd_en    = (state == FETCH) && !fifo_full;
  assign dut_inp_vld  = (state == SEND);
  // Chunk bus is forced to zero outside SEND so reset/idle outputs are clean.
  assign dut_inp      = dut_inp_vld ? padded[idx*BUS_W +: BUS_W] : '0;

  assign accept     = dut_inp_vld && !dut_stall;
  assign last_chunk = (idx == LAST_IDX);
  // Results are scored only while a run is active; abort drops its cycle.
  assign result_ok  = dut_outp_vld && busy && !abort;
  assign fifo_push  = accept && last_chunk;
  assign fifo_pop   = result_ok && !fifo_empty;
  assign fifo_flush = abort || (start && idle_or_done);

  label_fifo #(
    .WIDTH (LABEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_label_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (label_q),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sample capture: zero-extension supplies the pad bits of the last chunk.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      padded  <= PAD_W'(smp_data);
      label_q <= smp_label;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      smp_addr      <= '0;
      samples_seen  <= '0;
      correct_cnt   <= '0;
      err_underflow <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= FETCH;
            idx           <= '0;
            smp_addr      <= '0;
            samples_seen  <= '0;
            correct_cnt   <= '0;
            err_underflow <= 1'b0;
          end
        end
        // The read strobe only fires when a label slot is free, which bounds
        // the number of samples in flight to the FIFO depth.
        FETCH: if (!fifo_full) state <= LOAD;
        LOAD:  state <= SEND;
        SEND: begin
          if (accept) begin
            if (last_chunk) begin
              idx      <= '0;
              smp_addr <= smp_addr + 1'b1;
              state    <= (smp_addr == LAST_ADDR) ? DRAIN : FETCH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAIN: if (samples_seen == MAX_CNT) state <= DONE;
        default: state <= IDLE;
      endcase

      if (result_ok) begin
        if (samples_seen != MAX_CNT) samples_seen <= samples_seen + 1'b1;
        if (fifo_empty) begin
          err_underflow <= 1'b1;
        end else if ((fifo_head == dut_outp) && (correct_cnt != MAX_CNT)) begin
          correct_cnt <= correct_cnt + 1'b1;
        end
      end
    end
  end

endmodule
